pc_sequencer: RTL and testbench

- Owns the program counter and sequences instruction fetch for the single-cycle CPU.
- Runs a req/ack handshake with instruction memory and holds the fetched instruction for decode.
- On each retire it selects the next PC: sequential, branch, jump (upper PC nibble concatenated with the 26-bit index), or jump-register.
- Sits between the instruction memory port and the decode/control unit.

---
 rtl/pc_sequencer_pkg.sv | 32 +++
 rtl/pc_sequencer_next_pc_sel.sv | 39 +++
 rtl/pc_sequencer.sv | 120 ++++++++++++
 tb/tb_pc_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer: FSM states,
// next-PC source codes and the redirect priority encoder.
package pc_sequencer_pkg;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT,
    S_ERR
  } state_t;

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_J,
    SEL_JR
  } sel_t;

  // Redirect priority: jump-register, then jump, then branch, then fall-through.
  function automatic sel_t pick_sel(input logic jump_reg,
                                    input logic jump,
                                    input logic branch_taken);
    if (jump_reg)          return SEL_JR;
    else if (jump)         return SEL_J;
    else if (branch_taken) return SEL_BR;
    else                   return SEL_SEQ;
  endfunction

endpackage

// File: rtl/pc_sequencer_next_pc_sel.sv
// Combinational next-PC selector: resolves simultaneous redirect requests by
// priority and flags a misaligned jump-register target.
module next_pc_sel
  import pc_sequencer_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [31:0] jr_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  sel_t sel;

  assign pc_plus4 = pc + PC_STEP;

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    sel        = pick_sel(jump_reg, jump, branch_taken);
    next_pc    = pc_plus4;
    misaligned = 1'b0;
    case (sel)
      SEL_JR: begin
        next_pc    = jr_target;
        misaligned = |jr_target[1:0];
      end
      SEL_J:   next_pc = {pc_plus4[31:28], jump_index, 2'b00};
      // Offset is in words; the shift and add wrap modulo 2^32.
      SEL_BR:  next_pc = pc_plus4 + {branch_offset[29:0], 2'b00};
      default: next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner and fetch sequencer: req/ack fetch from instruction
// memory, holds the instruction for decode and selects the next PC on retire.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC         = 32'h0000_0000,
  parameter bit          HALT_ON_MISALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        advance,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [31:0] jr_target,
  input  logic        halt,
  output logic [31:0] retired,
  output logic        err
);

  state_t      state, state_nx;
  logic [31:0] next_pc;
  logic        misaligned;
  logic        fetch_done;
  logic        exec_go;
  logic        trap;

  next_pc_sel u_next_pc_sel (
    .pc            (pc),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .jump_reg      (jump_reg),
    .jr_target     (jr_target),
    .pc_plus4      (pc_plus4),
    .next_pc       (next_pc),
    .misaligned    (misaligned)
  );

  // Acks and advances are only meaningful in their own state.
  assign fetch_done = (state == S_FETCH) && imem_ack;
  assign exec_go    = (state == S_EXEC) && advance;
  assign trap       = exec_go && !halt && misaligned && HALT_ON_MISALIGN;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = S_FETCH;
      S_FETCH: if (imem_ack) state_nx = S_EXEC;
      S_EXEC: begin
        if (advance) begin
          if (halt)                                   state_nx = S_HALT;
          else if (misaligned && HALT_ON_MISALIGN)    state_nx = S_ERR;
          else                                        state_nx = S_FETCH;
        end
      end
      S_HALT:  state_nx = S_HALT;
      S_ERR:   state_nx = S_ERR;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs decode from the state register alone, so reset drops imem_req
  // without waiting for a clock edge.
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      S_FETCH: imem_req    = 1'b1;
      S_EXEC:  instr_valid = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr = pc;

  // NOTE: instr is a single architectural register, not a memory, so it is
  // reset alongside pc to give decode a defined value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      instr   <= 32'h0;
      retired <= 32'h0;
      err     <= 1'b0;
    end else begin
      if (fetch_done) instr <= imem_rdata;
      if (exec_go) begin
        if (halt) begin
          retired <= retired + 32'd1;
        end else if (trap) begin
          err <= 1'b1;
        end else begin
          // Clearing the low bits is a no-op for aligned targets and
          // implements the continue-on-misalign mode.
          pc      <= next_pc & ~32'h3;
          retired <= retired + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: two instances (halt / continue on
// misalign) driven in lockstep against a plain-arithmetic reference model.
module tb_pc_sequencer;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] retired;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        advance = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_offset = 32'h0;
  logic        jump = 1'b0;
  logic [25:0] jump_index = 26'h0;
  logic        jump_reg = 1'b0;
  logic [31:0] jr_target = 32'h0;
  logic        halt = 1'b0;

  logic        imem_req_a, instr_valid_a, err_a;
  logic [31:0] imem_addr_a, instr_a, pc_a, pc_plus4_a, retired_a;
  logic        imem_req_b, instr_valid_b, err_b;
  logic [31:0] imem_addr_b, instr_b, pc_b, pc_plus4_b, retired_b;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  logic [31:0] model_pc = 32'h0;
  logic [31:0] model_retired = 32'h0;
  logic [31:0] last_instr = 32'h0;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(32'h0000_0000), .HALT_ON_MISALIGN(1'b1)) u_dut_a (
    .clk (clk), .rst_n (rst_n),
    .imem_req (imem_req_a), .imem_addr (imem_addr_a),
    .imem_ack (imem_ack), .imem_rdata (imem_rdata),
    .instr_valid (instr_valid_a), .instr (instr_a),
    .pc (pc_a), .pc_plus4 (pc_plus4_a),
    .advance (advance), .branch_taken (branch_taken), .branch_offset (branch_offset),
    .jump (jump), .jump_index (jump_index), .jump_reg (jump_reg), .jr_target (jr_target),
    .halt (halt), .retired (retired_a), .err (err_a)
  );

  pc_sequencer #(.RESET_PC(32'h0000_0000), .HALT_ON_MISALIGN(1'b0)) u_dut_b (
    .clk (clk), .rst_n (rst_n),
    .imem_req (imem_req_b), .imem_addr (imem_addr_b),
    .imem_ack (imem_ack), .imem_rdata (imem_rdata),
    .instr_valid (instr_valid_b), .instr (instr_b),
    .pc (pc_b), .pc_plus4 (pc_plus4_b),
    .advance (advance), .branch_taken (branch_taken), .branch_offset (branch_offset),
    .jump (jump), .jump_index (jump_index), .jump_reg (jump_reg), .jr_target (jr_target),
    .halt (halt), .retired (retired_b), .err (err_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference next-PC rule, straight from the architectural definition.
  function automatic logic [31:0] ref_next(input logic [31:0] p,
                                           input logic jr, input logic [31:0] jt,
                                           input logic j, input logic [25:0] ji,
                                           input logic br, input logic [31:0] bo);
    logic [31:0] seq;
    seq = p + 32'd4;
    if (jr) return jt;
    if (j)  return {seq[31:28], ji, 2'b00};
    if (br) return seq + bo * 32'd4;
    return seq;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic junk_redirects();
    branch_offset = $urandom;
    jump_index    = 26'($urandom);
    jr_target     = $urandom;
    branch_taken  = 1'($urandom);
    jump          = 1'($urandom);
    jump_reg      = 1'($urandom);
    halt          = 1'($urandom);
  endtask

  // Wait for a request, hold it lat cycles (with stray advances), then ack.
  task automatic do_fetch(input int lat, input logic [31:0] data);
    int n;
    n = 0;
    while (!imem_req_a && n < 50) begin
      tick();
      n++;
    end
    check("fetch_req", {31'b0, imem_req_a}, 32'h1);
    check("fetch_addr", imem_addr_a, model_pc);
    for (int i = 0; i < lat; i++) begin
      advance = 1'($urandom);
      junk_redirects();
      tick();
    end
    advance    = 1'b0;
    halt       = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = data;
    exp_q.push_back('{pc: model_pc, instr: data, retired: model_retired});
    last_instr = data;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
  endtask

  // Wait w cycles in EXEC (with stray acks), then retire with the given redirects.
  task automatic do_exec(input int w, input logic h,
                         input logic jr, input logic [31:0] jt,
                         input logic j, input logic [25:0] ji,
                         input logic br, input logic [31:0] bo);
    for (int i = 0; i < w; i++) begin
      imem_ack   = 1'($urandom);
      imem_rdata = $urandom;
      tick();
    end
    imem_ack      = 1'b0;
    advance       = 1'b1;
    halt          = h;
    jump_reg      = jr;
    jr_target     = jt;
    jump          = j;
    jump_index    = ji;
    branch_taken  = br;
    branch_offset = bo;
    if (!h) model_pc = ref_next(model_pc, jr, jt, j, ji, br, bo);
    model_retired = model_retired + 32'd1;
    tick();
    advance = 1'b0;
    junk_redirects();
    halt = 1'b0;
  endtask

  task automatic model_reset();
    model_pc      = 32'h0;
    model_retired = 32'h0;
    last_instr    = 32'h0;
  endtask

  // Monitor: every new instruction presented to decode is matched against the scoreboard.
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && instr_valid_a && !prev_v) begin
      if (exp_q.size() == 0) begin
        check("unexpected_instr_valid", {31'b0, instr_valid_a}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("mon_pc_a", pc_a, e.pc);
        check("mon_instr_a", instr_a, e.instr);
        check("mon_retired_a", retired_a, e.retired);
        check("mon_pc_b", pc_b, e.pc);
        check("mon_instr_b", instr_b, e.instr);
      end
    end
    prev_v = instr_valid_a;
  end

  initial begin
    logic [31:0] r;
    logic        fj, fjr, fbr;

    #3 rst_n = 1'b0;
    repeat (2) tick();
    check("rst_imem_req", {31'b0, imem_req_a}, 32'h0);
    check("rst_instr_valid", {31'b0, instr_valid_a}, 32'h0);
    check("rst_pc", pc_a, 32'h0);
    check("rst_instr", instr_a, 32'h0);
    check("rst_retired", retired_a, 32'h0);
    check("rst_err", {31'b0, err_a}, 32'h0);
    model_reset();

    @(negedge clk) rst_n = 1'b1;
    #1 check("idle_no_req", {31'b0, imem_req_a}, 32'h0);
    tick();
    check("fetch_after_idle", {31'b0, imem_req_a}, 32'h1);

    // First instruction: ack in the request cycle, advance one cycle later.
    do_fetch(0, 32'h2008_0005);
    check("valid_after_ack", {31'b0, instr_valid_a}, 32'h1);
    do_exec(1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    check("first_pc", pc_a, 32'h0000_0004);
    check("first_retired", retired_a, 32'h1);

    do_fetch(1, $urandom);
    do_exec(0, 1'b0, 1'b1, 32'h1000_0040, 1'b0, 26'h0, 1'b0, 32'h0);
    do_fetch(2, $urandom);
    do_exec(2, 1'b0, 1'b0, 32'h0, 1'b1, 26'h000_0010, 1'b0, 32'h0);
    check("jump_pc", pc_a, 32'h1000_0040);

    do_fetch(0, $urandom);
    do_exec(0, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 26'h0, 1'b0, 32'h0);
    do_fetch(0, $urandom);
    do_exec(1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'hFFFF_FFFE);
    check("branch_back_pc", pc_a, 32'h0000_00FC);

    do_fetch(3, $urandom);
    do_exec(0, 1'b0, 1'b1, 32'h0000_2000, 1'b1, 26'h3FF_FFFF, 1'b1, 32'h0000_0100);
    check("jr_priority_pc", pc_a, 32'h0000_2000);

    do_fetch(0, $urandom);
    do_exec(0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 26'h0, 1'b0, 32'h0);
    do_fetch(1, $urandom);
    do_exec(0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    check("pc_wrap", pc_a, 32'h0000_0000);

    for (int k = 0; k < 40; k++) begin
      do_fetch($urandom_range(0, 3), $urandom);
      r   = $urandom;
      fjr = ($urandom_range(0, 3) == 0);
      fj  = ($urandom_range(0, 3) == 0);
      fbr = 1'($urandom);
      do_exec($urandom_range(0, 2), 1'b0, fjr, r & 32'hFFFF_FFFC,
              fj, 26'($urandom), fbr, $urandom);
      check("rand_pc_a", pc_a, model_pc);
      check("rand_pc_b", pc_b, model_pc);
    end
    check("rand_retired", retired_a, model_retired);

    // Misaligned jump-register target: one instance traps, the other continues aligned.
    do_fetch(1, $urandom);
    advance   = 1'b1;
    jump_reg  = 1'b1;
    jr_target = 32'h0000_2002;
    jump = 1'b0; branch_taken = 1'b0; halt = 1'b0;
    tick();
    advance = 1'b0;
    check("mis_err_a", {31'b0, err_a}, 32'h1);
    check("mis_req_a", {31'b0, imem_req_a}, 32'h0);
    check("mis_pc_a", pc_a, model_pc);
    check("mis_retired_a", retired_a, model_retired);
    check("mis_err_b", {31'b0, err_b}, 32'h0);
    check("mis_pc_b", pc_b, 32'h0000_2000);
    check("mis_retired_b", retired_b, model_retired + 32'd1);
    tick();
    check("mis_req_a_held", {31'b0, imem_req_a}, 32'h0);
    check("mis_valid_a", {31'b0, instr_valid_a}, 32'h0);
    check("mis_err_a_sticky", {31'b0, err_a}, 32'h1);
    check("mis_addr_b", imem_addr_b, 32'h0000_2000);

    // Reset in the middle of a fetch whose ack is late.
    rst_n = 1'b0;
    repeat (2) tick();
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    do_fetch(0, $urandom);
    do_exec(0, 1'b0, 1'b1, 32'h0000_0400, 1'b0, 26'h0, 1'b0, 32'h0);
    tick();
    check("pre_rst_req", {31'b0, imem_req_a}, 32'h1);
    #2 rst_n = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1 check("rst_drops_req_a", {31'b0, imem_req_a}, 32'h0);
    check("rst_drops_req_b", {31'b0, imem_req_b}, 32'h0);
    repeat (2) tick();
    check("rst_ack_ignored", instr_a, 32'h0);
    check("rst2_pc", pc_a, 32'h0);
    check("rst2_retired", retired_a, 32'h0);
    imem_ack = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    do_fetch(2, $urandom);
    do_exec(0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    check("restart_pc", pc_a, 32'h0000_0004);

    // Halt at pc 0x10: terminal, later acks and advances have no effect.
    do_fetch(0, $urandom);
    do_exec(0, 1'b0, 1'b1, 32'h0000_0010, 1'b0, 26'h0, 1'b0, 32'h0);
    do_fetch(1, $urandom);
    do_exec(1, 1'b1, 1'b1, 32'h0000_0400, 1'b0, 26'h0, 1'b0, 32'h0);
    check("halt_pc", pc_a, 32'h0000_0010);
    check("halt_retired", retired_a, model_retired);
    check("halt_valid", {31'b0, instr_valid_a}, 32'h0);
    check("halt_req", {31'b0, imem_req_a}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      imem_ack   = 1'b1;
      imem_rdata = $urandom;
      advance    = 1'b1;
      jump_reg   = 1'b1;
      jr_target  = 32'h0000_0800;
      tick();
    end
    imem_ack = 1'b0;
    advance  = 1'b0;
    check("halt_pc_held", pc_a, 32'h0000_0010);
    check("halt_retired_held", retired_a, model_retired);
    check("halt_instr_held", instr_a, last_instr);
    check("halt_req_held", {31'b0, imem_req_a}, 32'h0);
    check("halt_pc_b", pc_b, 32'h0000_0010);

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
